vend_param: RTL

//  Parametrised vending-machine controller: price, credit width and change policy set by parameter.

---
 rtl/vend_param.sv | 118 +++++++++++
 1 files changed

// File: rtl/vend_param.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | vend_param : parametrised coin-operated vending controller with change/refund     |
// | Rev 1.0                                                                           |
// +-----------------------------------------------------------------------------------+
module vend_param #(
    parameter int PRICE      = 3,
    parameter int CREDIT_W   = 4,
    parameter int MAX_CREDIT = 15,
    parameter int CHANGE_EN  = 1
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Nickel,
    input  logic                Dime,
    input  logic                Quarter,
    input  logic                CoinReturn,
    output logic                Dispense,
    output logic                ChangeNickel,
    output logic                CoinReject,
    output logic [CREDIT_W-1:0] Credit,
    output logic [2:0]          State
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_CREDIT = 3'b001,
        ST_VEND   = 3'b011,
        ST_CHANGE = 3'b010,
        ST_REFUND = 3'b101
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CREDIT_W-1:0]   credit_nxt;
    logic                  reject_nxt;
    logic [1:0]            coin_cnt;
    logic                  any_coin;
    logic [CREDIT_W:0]     coin_val;
    logic [CREDIT_W:0]     sum;
    logic [CREDIT_W-1:0]   remainder;

    assign coin_cnt  = {1'b0, Nickel} + {1'b0, Dime} + {1'b0, Quarter};
    assign any_coin  = Nickel | Dime | Quarter;
    assign coin_val  = Nickel ? (CREDIT_W+1)'(1) :
                       Dime   ? (CREDIT_W+1)'(2) :
                       Quarter? (CREDIT_W+1)'(5) : '0;
    // One extra bit so the overflow check against MAX_CREDIT cannot wrap
    assign sum       = {1'b0, Credit} + coin_val;
    assign remainder = Credit - CREDIT_W'(PRICE);

    always_comb begin
        state_nxt  = state;
        credit_nxt = Credit;
        reject_nxt = 1'b0;
        case (state)
            ST_IDLE, ST_CREDIT: begin
                if (state == ST_CREDIT && CoinReturn) begin
                    state_nxt  = ST_REFUND;
                    reject_nxt = any_coin;
                end else if (any_coin) begin
                    if (coin_cnt == 2'd1 && sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
                        credit_nxt = sum[CREDIT_W-1:0];
                        state_nxt  = (sum >= (CREDIT_W+1)'(PRICE)) ? ST_VEND : ST_CREDIT;
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                reject_nxt = any_coin;
                credit_nxt = remainder;
                if (remainder == '0)
                    state_nxt = ST_IDLE;
                else if (CHANGE_EN != 0)
                    state_nxt = ST_CHANGE;
                else if (remainder >= CREDIT_W'(PRICE))
                    state_nxt = ST_VEND;
                else
                    state_nxt = ST_CREDIT;
            end
            ST_CHANGE, ST_REFUND: begin
                reject_nxt = any_coin;
                if (Credit <= CREDIT_W'(1)) begin
                    credit_nxt = '0;
                    state_nxt  = ST_IDLE;
                end else begin
                    credit_nxt = Credit - CREDIT_W'(1);
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                credit_nxt = '0;
            end
        endcase
    end

    // Strobes are decoded from the next state so they line up with the state they belong to
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state        <= ST_IDLE;
            Credit       <= '0;
            Dispense     <= 1'b0;
            ChangeNickel <= 1'b0;
            CoinReject   <= 1'b0;
        end else begin
            state        <= state_nxt;
            Credit       <= credit_nxt;
            Dispense     <= (state_nxt == ST_VEND);
            ChangeNickel <= (state_nxt == ST_CHANGE) || (state_nxt == ST_REFUND);
            CoinReject   <= reject_nxt;
        end
    end

    assign State = state;

endmodule
`default_nettype wire
